// File: rtl/connect_n_if.sv
// Move/result handshake bundle for the connect_n engine.
// master = move producer / result consumer, slave = engine.
interface connect_n_if;
  logic       op_ready;
  logic       op_valid;
  logic       op_player_id;
  logic [3:0] op_col_id;
  logic       re_ready;
  logic       re_valid;
  logic       re_err;
  logic [1:0] re_err_code;
  logic [3:0] re_row_id;
  logic       re_is_finished;
  logic       re_winner;
  logic       re_tie;

  modport master (
    input  op_ready, re_valid, re_err, re_err_code, re_row_id,
           re_is_finished, re_winner, re_tie,
    output op_valid, op_player_id, op_col_id, re_ready
  );

  modport slave (
    output op_ready, re_valid, re_err, re_err_code, re_row_id,
           re_is_finished, re_winner, re_tie,
    input  op_valid, op_player_id, op_col_id, re_ready
  );
endinterface

// File: rtl/connect_n.sv
// Parametrised Connect-N engine: one move per handshake, one-cycle drop,
// then a cell-per-cycle walk of the four lines through the landed piece.
module connect_n #(
  parameter int ROWS    = 6,
  parameter int COLS    = 7,
  parameter int WIN_LEN = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  connect_n_if.slave  bus
);
  localparam int NC = ROWS * COLS;
  localparam int IW = $clog2(NC);
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int MW = $clog2(NC + 1);
  localparam logic signed [6:0] ROWS_S = 7'(ROWS);
  localparam logic signed [6:0] COLS_S = 7'(COLS);

  typedef enum logic [1:0] {WAIT_OP, PLACE, SCAN, RE} state_e;
  typedef enum logic [1:0] {D_V, D_H, D_RISE, D_FALL} dir_e;

  state_e                 state_q, state_d;
  dir_e                   dir_q, dir_d;
  logic [NC-1:0]          occ_q, occ_d, own_q, own_d;
  logic [COLS-1:0][4:0]   height_q, height_d;
  logic [MW-1:0]          moves_q, moves_d;
  logic                   turn_q, turn_d, player_q, player_d, neg_q, neg_d;
  logic [3:0]             col_q, col_d, row_q, row_d;
  logic [4:0]             k_q, k_d, cnt_q, cnt_d;
  logic                   re_err_q, re_err_d, re_fin_q, re_fin_d;
  logic                   re_win_q, re_win_d, re_tie_q, re_tie_d;
  logic [1:0]             re_code_q, re_code_d;
  logic [3:0]             re_row_q, re_row_d;

  // Scan geometry: offset of the probed cell from the landed piece.
  logic signed [6:0] k_s, dr, dc, tr, tc;
  logic              inb, hit;
  logic [IW-1:0]     sidx, lidx;
  logic [3:0]        land_row;
  logic [CW-1:0]     cidx;

  always_comb begin
    k_s = {2'b00, k_q};
    dr  = '0;
    dc  = '0;
    case (dir_q)
      D_V:    begin dr = k_s;  dc = '0;  end
      D_H:    begin dr = '0;   dc = k_s; end
      D_RISE: begin dr = -k_s; dc = k_s; end
      default: begin dr = k_s; dc = k_s; end
    endcase
    if (neg_q) begin
      dr = -dr;
      dc = -dc;
    end
    tr   = $signed({3'b000, row_q}) + dr;
    tc   = $signed({3'b000, col_q}) + dc;
    inb  = (tr >= 0) && (tr < ROWS_S) && (tc >= 0) && (tc < COLS_S);
    sidx = IW'(int'(tr[3:0]) * COLS + int'(tc[3:0]));
    hit  = inb && occ_q[sidx] && (own_q[sidx] == player_q);
    cidx = col_q[CW-1:0];
    land_row = 4'(ROWS - 1) - height_q[cidx][3:0];
    lidx = IW'(int'(land_row) * COLS + int'(col_q));
  end

  always_comb begin
    logic half_end;
    logic full;
    logic [1:0] code;
    state_d   = state_q;
    dir_d     = dir_q;
    occ_d     = occ_q;
    own_d     = own_q;
    height_d  = height_q;
    moves_d   = moves_q;
    turn_d    = turn_q;
    player_d  = player_q;
    neg_d     = neg_q;
    col_d     = col_q;
    row_d     = row_q;
    k_d       = k_q;
    cnt_d     = cnt_q;
    re_err_d  = re_err_q;
    re_code_d = re_code_q;
    re_row_d  = re_row_q;
    re_fin_d  = re_fin_q;
    re_win_d  = re_win_q;
    re_tie_d  = re_tie_q;
    half_end  = 1'b0;
    full      = (moves_q == MW'(NC));
    code      = 2'd0;

    case (state_q)
      WAIT_OP: if (bus.op_valid) begin
        player_d = bus.op_player_id;
        col_d    = bus.op_col_id;
        if ({1'b0, bus.op_col_id} >= 5'(COLS))                         code = 2'd2;
        else if (bus.op_player_id != turn_q)                           code = 2'd3;
        else if (height_q[bus.op_col_id[CW-1:0]] == 5'(ROWS))         code = 2'd1;
        if (code != 2'd0) begin
          re_err_d  = 1'b1;
          re_code_d = code;
          re_row_d  = '0;
          state_d   = RE;
        end else begin
          state_d = PLACE;
        end
      end
      PLACE: begin
        row_d          = land_row;
        occ_d[lidx]    = 1'b1;
        own_d[lidx]    = player_q;
        height_d[cidx] = height_q[cidx] + 5'd1;
        moves_d        = moves_q + MW'(1);
        cnt_d          = 5'd1;
        dir_d          = D_V;
        neg_d          = 1'b0;
        k_d            = 5'd1;
        state_d        = SCAN;
      end
      SCAN: begin
        if (hit) begin
          if (cnt_q + 5'd1 == 5'(WIN_LEN)) begin
            re_fin_d = 1'b1;
            re_win_d = player_q;
            re_row_d = row_q;
            state_d  = RE;
          end else begin
            cnt_d = cnt_q + 5'd1;
            if (k_q + 5'd1 == 5'(WIN_LEN)) half_end = 1'b1;
            else                           k_d = k_q + 5'd1;
          end
        end else begin
          half_end = 1'b1;
        end
        if (half_end) begin
          k_d = 5'd1;
          if (!neg_q) begin
            neg_d = 1'b1;
          end else if (dir_q == D_FALL) begin
            re_fin_d = full;
            re_tie_d = full;
            re_row_d = row_q;
            state_d  = RE;
          end else begin
            dir_d = dir_e'(dir_q + 2'd1);
            neg_d = 1'b0;
            cnt_d = 5'd1;
          end
        end
      end
      default: if (bus.re_ready) begin
        state_d   = WAIT_OP;
        re_err_d  = 1'b0;
        re_code_d = '0;
        re_row_d  = '0;
        re_fin_d  = 1'b0;
        re_win_d  = 1'b0;
        re_tie_d  = 1'b0;
        // A finished game restarts with player 0 on an empty board.
        if (re_fin_q) begin
          occ_d    = '0;
          own_d    = '0;
          height_d = '0;
          moves_d  = '0;
          turn_d   = 1'b0;
        end else if (!re_err_q) begin
          turn_d = ~turn_q;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= WAIT_OP;
      dir_q     <= D_V;
      occ_q     <= '0;
      own_q     <= '0;
      height_q  <= '0;
      moves_q   <= '0;
      turn_q    <= 1'b0;
      player_q  <= 1'b0;
      neg_q     <= 1'b0;
      col_q     <= '0;
      row_q     <= '0;
      k_q       <= '0;
      cnt_q     <= '0;
      re_err_q  <= 1'b0;
      re_code_q <= '0;
      re_row_q  <= '0;
      re_fin_q  <= 1'b0;
      re_win_q  <= 1'b0;
      re_tie_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      occ_q     <= occ_d;
      own_q     <= own_d;
      height_q  <= height_d;
      moves_q   <= moves_d;
      turn_q    <= turn_d;
      player_q  <= player_d;
      neg_q     <= neg_d;
      col_q     <= col_d;
      row_q     <= row_d;
      k_q       <= k_d;
      cnt_q     <= cnt_d;
      re_err_q  <= re_err_d;
      re_code_q <= re_code_d;
      re_row_q  <= re_row_d;
      re_fin_q  <= re_fin_d;
      re_win_q  <= re_win_d;
      re_tie_q  <= re_tie_d;
    end
  end

  assign bus.op_ready       = (state_q == WAIT_OP);
  assign bus.re_valid       = (state_q == RE);
  assign bus.re_err         = re_err_q;
  assign bus.re_err_code    = re_code_q;
  assign bus.re_row_id      = re_row_q;
  assign bus.re_is_finished = re_fin_q;
  assign bus.re_winner      = re_win_q;
  assign bus.re_tie         = re_tie_q;
endmodule

// File: tb/tb_connect_n.sv
// Bench for connect_n: three geometries on one clock, directed scenarios plus
// random play on the default board, checked against a board-level game model.
module tb_connect_n;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       op_valid, op_player, re_ready;
  logic [3:0] op_col;
  int         sel;
  int         checks = 0, failures = 0;

  always #5 clk = ~clk;

  connect_n_if b0 ();
  connect_n_if b1 ();
  connect_n_if b2 ();

  connect_n #(.ROWS(6), .COLS(7), .WIN_LEN(4)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  connect_n #(.ROWS(2), .COLS(2), .WIN_LEN(2)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  connect_n #(.ROWS(2), .COLS(3), .WIN_LEN(3)) u2 (.clk(clk), .rst_n(rst_n), .bus(b2));

  assign b0.op_valid = op_valid && (sel == 0);
  assign b1.op_valid = op_valid && (sel == 1);
  assign b2.op_valid = op_valid && (sel == 2);
  assign b0.op_player_id = op_player;
  assign b1.op_player_id = op_player;
  assign b2.op_player_id = op_player;
  assign b0.op_col_id = op_col;
  assign b1.op_col_id = op_col;
  assign b2.op_col_id = op_col;
  assign b0.re_ready = re_ready;
  assign b1.re_ready = re_ready;
  assign b2.re_ready = re_ready;

  logic [11:0] v0, v1, v2;
  logic        o_op_ready, o_re_valid, o_err, o_fin, o_win, o_tie;
  logic [1:0]  o_code;
  logic [3:0]  o_row;
  assign v0 = {b0.op_ready, b0.re_valid, b0.re_err, b0.re_err_code, b0.re_row_id,
               b0.re_is_finished, b0.re_winner, b0.re_tie};
  assign v1 = {b1.op_ready, b1.re_valid, b1.re_err, b1.re_err_code, b1.re_row_id,
               b1.re_is_finished, b1.re_winner, b1.re_tie};
  assign v2 = {b2.op_ready, b2.re_valid, b2.re_err, b2.re_err_code, b2.re_row_id,
               b2.re_is_finished, b2.re_winner, b2.re_tie};
  assign {o_op_ready, o_re_valid, o_err, o_code, o_row, o_fin, o_win, o_tie} =
         (sel == 1) ? v1 : (sel == 2) ? v2 : v0;

  // Game model: owner per cell (-1 empty), heights, move count, turn.
  int PR[3] = '{6, 2, 2};
  int PC[3] = '{7, 2, 3};
  int PW[3] = '{4, 2, 3};
  int m_own[3][16][16];
  int m_h[3][16];
  int m_cnt[3];
  int m_turn[3];
  int e_err, e_code, e_row, e_fin, e_win, e_tie, e_lat;
  int l_lat, l_row, l_fin, l_win, l_tie, l_code;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic void model_clear(int s);
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) m_own[s][r][c] = -1;
    for (int c = 0; c < 16; c++) m_h[s][c] = 0;
    m_cnt[s]  = 0;
    m_turn[s] = 0;
  endfunction

  function automatic void model_move(int s, int p, int c);
    int dr[4] = '{1, 0, -1, 1};
    int dc[4] = '{0, 1, 1, 1};
    int run, rr, cc, n;
    bit won;
    e_err = 0; e_code = 0; e_row = 0; e_fin = 0; e_win = 0; e_tie = 0;
    if (c >= PC[s])                 e_code = 2;
    else if (p != m_turn[s])        e_code = 3;
    else if (m_h[s][c] == PR[s])    e_code = 1;
    if (e_code != 0) begin
      e_err = 1;
      e_lat = 1;
      return;
    end
    e_row = PR[s] - 1 - m_h[s][c];
    m_own[s][e_row][c] = p;
    m_h[s][c]++;
    m_cnt[s]++;
    n = 0;
    won = 0;
    for (int d = 0; d < 4 && !won; d++) begin
      run = 1;
      for (int sg = 1; sg >= -1 && !won; sg -= 2) begin
        for (int k = 1; k < PW[s]; k++) begin
          n++;
          rr = e_row + k * dr[d] * sg;
          cc = c + k * dc[d] * sg;
          if (rr >= 0 && rr < PR[s] && cc >= 0 && cc < PC[s] && m_own[s][rr][cc] == p) begin
            run++;
            if (run == PW[s]) begin
              won = 1;
              break;
            end
          end else break;
        end
      end
    end
    e_lat = 2 + n;
    e_fin = (won || m_cnt[s] == PR[s] * PC[s]) ? 1 : 0;
    e_win = won ? p : 0;
    e_tie = (!won && m_cnt[s] == PR[s] * PC[s]) ? 1 : 0;
    if (e_fin != 0) model_clear(s);
    else            m_turn[s] ^= 1;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    for (int s = 0; s < 3; s++) model_clear(s);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic send_op(input int p, input int c);
    int w = 0;
    @(negedge clk);
    while (!o_op_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("op_ready_wait", o_op_ready, 1);
    op_player = p[0];
    op_col    = c[3:0];
    op_valid  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    op_valid = 1'b0;
  endtask

  task automatic move(input int s, input int p, input int c, input int hold);
    logic [11:0] snap, now;
    sel = s;
    re_ready = (hold == 0);
    model_move(s, p, c);
    send_op(p, c);
    l_lat = 1;
    while (!o_re_valid && l_lat < 100) begin
      @(negedge clk);
      l_lat++;
    end
    chk("latency", l_lat, e_lat);
    chk("re_err", o_err, e_err);
    chk("re_err_code", o_code, e_code);
    chk("re_row_id", o_row, e_row);
    chk("re_is_finished", o_fin, e_fin);
    chk("re_winner", o_win, e_win);
    chk("re_tie", o_tie, e_tie);
    chk("excl_op_ready", o_op_ready, 0);
    l_row = o_row; l_fin = o_fin; l_win = o_win; l_tie = o_tie; l_code = o_code;
    snap = {o_op_ready, o_re_valid, o_err, o_code, o_row, o_fin, o_win, o_tie};
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      now = {o_op_ready, o_re_valid, o_err, o_code, o_row, o_fin, o_win, o_tie};
      chk("bp_stable", now, snap);
      op_player = ~p[0];
      op_col    = 4'd2;
      op_valid  = (i % 2 == 0);
    end
    if (hold > 0) begin
      @(negedge clk);
      op_valid = 1'b0;
      re_ready = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    chk("post_op_ready", o_op_ready, 1);
    chk("post_re_clear", {o_re_valid, o_err, o_code, o_row, o_fin, o_win, o_tie}, 0);
  endtask

  initial begin
    int p, c;
    op_valid = 1'b0; op_player = 1'b0; op_col = '0; re_ready = 1'b1; sel = 0;
    do_reset();
    @(negedge clk);
    chk("rst_op_ready", o_op_ready, 1);
    chk("rst_re_outputs", {o_re_valid, o_err, o_code, o_row, o_fin, o_win, o_tie}, 0);

    move(0, 0, 3, 0);
    chk("first_lat", l_lat, 10);
    chk("first_row", l_row, 5);

    do_reset();
    for (int i = 0; i < 7; i++) move(0, i % 2, i % 2, 0);
    chk("vwin_lat", l_lat, 5);
    chk("vwin_row", l_row, 2);
    chk("vwin_fin", l_fin, 1);
    move(0, 0, 0, 0);
    chk("vwin_cleared_row", l_row, 5);

    do_reset();
    move(0, 1, 0, 0);
    chk("err_turn_code", l_code, 3);
    move(0, 0, 9, 0);
    chk("err_range_code", l_code, 2);
    for (int i = 0; i < 6; i++) move(0, i % 2, 0, 0);
    move(0, 0, 0, 0);
    chk("err_full_code", l_code, 1);
    move(0, 0, 1, 0);
    chk("after_full_row", l_row, 5);

    move(0, 1, 4, 10);
    move(0, 0, 2, 0);
    chk("bp_ignored_row", l_row, 5);

    move(1, 0, 0, 0);
    move(1, 1, 1, 0);
    move(1, 0, 0, 0);
    chk("small_win_row", l_row, 0);
    chk("small_win_fin", l_fin, 1);

    move(2, 0, 0, 0);
    move(2, 1, 1, 0);
    move(2, 0, 2, 0);
    move(2, 1, 0, 0);
    move(2, 0, 1, 0);
    move(2, 1, 2, 0);
    chk("tie_flag", l_tie, 1);
    chk("tie_winner", l_win, 0);

    do_reset();
    sel = 0;
    send_op(0, 3);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midscan_op_ready", o_op_ready, 1);
    chk("midscan_re_valid", o_re_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int s = 0; s < 3; s++) model_clear(s);
    move(0, 0, 3, 0);
    chk("midscan_next_row", l_row, 5);

    do_reset();
    for (int i = 0; i < 200; i++) begin
      p = m_turn[0] ^ (($urandom % 8) == 0 ? 1 : 0);
      c = $urandom_range(0, 8);
      move(0, p, c, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/connect_n.md
# connect_n

Parametrised Connect-N game engine; the successor to the fixed 6x7, four-in-a-row engine. It accepts one move per valid/ready handshake and enforces turn order and column legality. Each piece lands in one cycle from per-column fill counters. Win detection walks only the lines through the landed piece, one cell per cycle, and the result is returned on a second valid/ready channel.

## Interface
- ROWS, 6, board height; 2..16, ROWS >= WIN_LEN
- COLS, 7, board width; 2..16, COLS >= WIN_LEN
- WIN_LEN, 4, pieces in a line needed to win; >= 2
- clk  in  1  clock; all state changes on the rising edge
- rst_n  in  1  asynchronous active-low reset
- op_ready  out  1  engine accepts a move
- op_valid  in  1  move present
- op_player_id  in  1  mover, 0 or 1
- op_col_id  in  4  target column
- re_ready  in  1  consumer accepts the result
- re_valid  out  1  result present
- re_err  out  1  move rejected
- re_err_code  out  2  0 none, 1 column full, 2 column out of range (>= COLS), 3 wrong turn
- re_row_id  out  4  landing row, row 0 = top; 0 when re_err
- re_is_finished  out  1  game over (win or tie)
- re_winner  out  1  winning player; 0 unless win
- re_tie  out  1  board full with no win

## Operation
- State: per-cell occupied/owner bits (index r*COLS+c); per-column height[c] (0..ROWS); move counter (0..ROWS*COLS); expected player turn (reset 0).
- The error check runs in priority order, first match wins: out of range (2), then wrong turn (3), then full column, height == ROWS (1).
- On error, board, turn and counter are unchanged.
- States: WAIT_OP -> (error) RE; WAIT_OP -> PLACE -> SCAN -> RE -> WAIT_OP.
- WAIT_OP: op_ready=1. A handshake captures player and column and drops op_ready.
- PLACE (1 cycle):
  - landing row = ROWS-1-height[c]
  - set occupied and owner bits
  - height[c]++, counter++
  - cnt=1, direction V, sign +, k=1
- SCAN: one check per cycle of cell (row + k*dr*s, col + k*dc*s).
  - Directions in order: V (dr,dc)=(+1,0), H (0,+1), RISE (-1,+1), FALL (+1,+1). Each direction is scanned with s=+1, then s=-1.
  - Hit = cell in bounds, occupied, and owned by the mover: cnt++, k++.
  - Miss, or k reaching WIN_LEN after a hit: end this half. Move to the next sign, or to the next direction with cnt=1; k resets to 1.
  - cnt == WIN_LEN: win. re_is_finished=1, re_winner=player, go to RE.
  - All 8 halves done without a win: re_is_finished = (counter == ROWS*COLS), re_tie = same; go to RE.
- RE: outputs stable while re_valid && !re_ready.
  - On the re handshake: re_* clear to 0, op_ready=1.
  - If the move was legal, turn toggles.
  - If re_is_finished, board, heights, counter and turn clear to 0.

## Timing
- Reset values:
  - op_ready=1; all re_* outputs 0
  - board, heights and counter 0; turn 0; state WAIT_OP
- Reset mid-operation (any state) aborts the move and returns to these values.
- Op handshake in cycle t:
  - error: re_valid=1 from cycle t+1
  - legal move: PLACE in t+1, SCAN from t+2, re_valid=1 from cycle t+2+N, where N = number of scan checks
  - N is at most 8*(WIN_LEN-1)
- op_ready and re_valid are never high in the same cycle.
- Next op_ready=1 is the cycle after the re handshake.
- op_valid is ignored outside WAIT_OP. Inputs are sampled only at the handshake.
- A winning line that also fills the board reports a win: re_tie=0.

## Test plan
- Reset, then P0 to col 3 with re_ready=1 -> re_valid at t+2+8 (all halves miss on an empty neighbourhood); re_row_id=5, re_err=0, re_is_finished=0; op_ready returns 1.
- Vertical win, defaults: P0 c0, P1 c1, P0 c0, P1 c1, P0 c0, P1 c1, P0 c0 -> last result arrives at t+5 (3 V+ hits) with re_row_id=2, re_is_finished=1, re_winner=0. The next move P0 c0 lands in row 5, proving the board cleared.
- Errors:
  - P1 as first move -> re_err=1, code 3, at t+1
  - P0 c9 -> code 2
  - filling c0 with 6 alternating moves, then a 7th -> code 1, board and turn unchanged
- Backpressure: hold re_ready=0 for 10 cycles during a result -> all re_* stable, op_ready=0, op_valid pulses ignored. Release -> handshake, op_ready=1 next cycle.
- ROWS=2, COLS=2, WIN_LEN=2: P0 c0, P1 c1, P0 c0 -> win with re_row_id=0.
- ROWS=2, COLS=3, WIN_LEN=3: P0 c0, P1 c1, P0 c2, P1 c0, P0 c1, P1 c2 -> sixth result re_tie=1, re_is_finished=1, re_winner=0.
- Assert rst_n mid-SCAN -> op_ready=1, re_valid=0 immediately; the next move lands in the bottom row.
